pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - run/step/halt controller driving the pipeline enable
// Optional executed-cycle counter enabled by defining PIPE_CTRL_CYCLE_COUNT_EN;
// without it o_cycle_count is tied to zero and CLEAR only changes state.
module pipeline_ctrl #(
  parameter int NB_STEP   = 8,
  parameter int NB_CYCLES = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  input  logic [NB_STEP-1:0]   i_step_count,
  input  logic                 i_halt_detected,
  output logic                 o_pipeline_enable,
  output logic [1:0]           o_state,
  output logic                 o_done,
  output logic                 o_cmd_error,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_HALT  = 2'b11;

  state_t               state_q;
  logic                 enable_q;
  logic                 done_q;
  logic                 cmd_error_q;
  logic [NB_STEP-1:0]   step_q;

  // FSM: retired halt has top priority, then HALT command, then step expiry.
  // An illegal command arriving in the same cycle as a termination is dropped
  // so done and cmd_error never coincide.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      done_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      step_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd == CMD_RUN) begin
              state_q  <= ST_RUN;
              enable_q <= 1'b1;
            end else if (i_cmd == CMD_STEP) begin
              state_q  <= ST_STEP;
              enable_q <= 1'b1;
              step_q   <= (i_step_count == '0) ? NB_STEP'(1) : i_step_count;
            end
          end
        end
        ST_RUN: begin
          if (i_halt_detected) begin
            state_q  <= ST_DONE;
            enable_q <= 1'b0;
            done_q   <= 1'b1;
          end else if (i_cmd_valid) begin
            if (i_cmd == CMD_HALT) begin
              state_q  <= ST_IDLE;
              enable_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cmd_error_q <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (i_halt_detected) begin
            state_q  <= ST_DONE;
            enable_q <= 1'b0;
            done_q   <= 1'b1;
            step_q   <= '0;
          end else if (i_cmd_valid && i_cmd == CMD_HALT) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            done_q   <= 1'b1;
            step_q   <= '0;
          end else if (step_q == NB_STEP'(1)) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            done_q   <= 1'b1;
            step_q   <= '0;
          end else begin
            step_q <= step_q - NB_STEP'(1);
            if (i_cmd_valid) begin
              cmd_error_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (i_cmd_valid) begin
            if (i_cmd == CMD_CLEAR) begin
              state_q <= ST_IDLE;
            end else begin
              cmd_error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_state           = state_q;
  assign o_pipeline_enable = enable_q;
  assign o_done            = done_q;
  assign o_cmd_error       = cmd_error_q;

`ifdef PIPE_CTRL_CYCLE_COUNT_EN
  logic                 clear_evt;
  logic [NB_CYCLES-1:0] cycles_q;
  logic [NB_CYCLES-1:0] cycles_d;

  assign clear_evt = i_cmd_valid && (i_cmd == CMD_CLEAR) &&
                     (state_q == ST_IDLE || state_q == ST_DONE);

  // Next count: CLEAR zeroes, otherwise count enabled cycles and saturate.
  always_comb begin
    cycles_d = cycles_q;
    if (clear_evt) begin
      cycles_d = '0;
    end else if (enable_q && cycles_q != '1) begin
      cycles_d = cycles_q + NB_CYCLES'(1);
    end
  end

  // Executed-cycle counter register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign o_cycle_count = cycles_q;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_DONE = 2'b11;
  localparam logic [1:0] C_CLEAR = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;

  logic       i_clock;
  logic       i_reset;
  logic       i_cmd_valid;
  logic [1:0] i_cmd;
  logic [7:0] i_step_count;
  logic       i_halt_detected;
  logic       o_pipeline_enable;
  logic [1:0] o_state;
  logic       o_done;
  logic       o_cmd_error;
  logic [3:0] o_cycle_count;

  pipeline_ctrl #(.NB_STEP(8), .NB_CYCLES(4)) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_cmd_valid       (i_cmd_valid),
    .i_cmd             (i_cmd),
    .i_step_count      (i_step_count),
    .i_halt_detected   (i_halt_detected),
    .o_pipeline_enable (o_pipeline_enable),
    .o_state           (o_state),
    .o_done            (o_done),
    .o_cmd_error       (o_cmd_error),
    .o_cycle_count     (o_cycle_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    int         scen;
    logic [1:0] st;
    logic       en;
    logic       dn;
    logic       er;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cur_scen = 0;

  // Scoreboard consumer: one expectation per driven cycle, checked after the edge.
  always @(posedge i_clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (o_state !== mon_e.st || o_pipeline_enable !== mon_e.en || o_done !== mon_e.dn ||
          o_cmd_error !== mon_e.er || o_cycle_count !== mon_e.cnt) begin
        fails++;
        $display("FAIL cycle_chk scen=%0d t=%0t got st=%0d en=%0b done=%0b err=%0b cnt=%0d need st=%0d en=%0b done=%0b err=%0b cnt=%0d",
                 mon_e.scen, $time, o_state, o_pipeline_enable, o_done, o_cmd_error, o_cycle_count,
                 mon_e.st, mon_e.en, mon_e.dn, mon_e.er, mon_e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and push the outputs expected after the next edge.
  task automatic drive(input logic v, input logic [1:0] c, input logic [7:0] n, input logic h,
                       input logic [1:0] st, input logic en, input logic dn, input logic er,
                       input int cnt);
    exp_t e;
    @(negedge i_clock);
    i_cmd_valid     = v;
    i_cmd           = c;
    i_step_count    = n;
    i_halt_detected = h;
    e.scen = cur_scen;
    e.st   = st;
    e.en   = en;
    e.dn   = dn;
    e.er   = er;
    e.cnt  = CNT_EN ? 4'(cnt) : 4'd0;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge i_clock);
    #2;
  endtask

  task automatic test_reset();
    cur_scen = 0;
    i_cmd_valid = 0; i_cmd = 0; i_step_count = 0; i_halt_detected = 0;
    i_reset = 1'b1;
    #2 i_reset = 1'b0;
    #1;
    tests++;
    if (o_state !== S_IDLE || o_pipeline_enable !== 1'b0 || o_done !== 1'b0 ||
        o_cmd_error !== 1'b0 || o_cycle_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_state got st=%0d en=%0b done=%0b err=%0b cnt=%0d need all zero",
               o_state, o_pipeline_enable, o_done, o_cmd_error, o_cycle_count);
    end
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  task automatic test_step3();
    cur_scen = 1;
    drive(1, C_STEP, 8'd3, 0, S_STEP, 1, 0, 0, 0);
    drive(0, C_CLEAR, 0, 0, S_STEP, 1, 0, 0, 1);
    drive(0, C_CLEAR, 0, 0, S_STEP, 1, 0, 0, 2);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 1, 0, 3);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 3);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_step_zero();
    cur_scen = 2;
    drive(1, C_STEP, 8'd0, 0, S_STEP, 1, 0, 0, 0);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 1, 0, 1);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 1);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_run_halt_detected();
    cur_scen = 3;
    drive(1, C_RUN, 0, 0, S_RUN, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) drive(0, C_CLEAR, 0, 0, S_RUN, 1, 0, 0, k);
    drive(0, C_CLEAR, 0, 1, S_DONE, 0, 1, 0, 10);
    drive(1, C_RUN, 0, 0, S_DONE, 0, 0, 1, 10);
    drive(0, C_CLEAR, 0, 1, S_DONE, 0, 0, 0, 10);
    drive(1, C_STEP, 8'd2, 0, S_DONE, 0, 0, 1, 10);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
    settle();
    tests++;
    if (o_state !== S_IDLE) begin
      fails++;
      $display("FAIL done_clear_state got %0d need %0d", o_state, S_IDLE);
    end
  endtask

  task automatic test_run_errors();
    cur_scen = 4;
    drive(1, C_RUN, 0, 0, S_RUN, 1, 0, 0, 0);
    drive(1, C_STEP, 8'd4, 0, S_RUN, 1, 0, 1, 1);
    drive(1, C_CLEAR, 0, 0, S_RUN, 1, 0, 1, 2);
    drive(1, C_RUN, 0, 0, S_RUN, 1, 0, 1, 3);
    drive(0, C_CLEAR, 0, 0, S_RUN, 1, 0, 0, 4);
    drive(1, C_HALT, 0, 0, S_IDLE, 0, 1, 0, 5);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 5);
    drive(1, C_HALT, 0, 0, S_IDLE, 0, 0, 0, 5);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
    drive(0, C_CLEAR, 0, 1, S_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_step_halt_expiry();
    cur_scen = 5;
    drive(1, C_STEP, 8'd5, 0, S_STEP, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) drive(0, C_CLEAR, 0, 0, S_STEP, 1, 0, 0, k);
    drive(0, C_CLEAR, 0, 1, S_DONE, 0, 1, 0, 5);
    drive(0, C_CLEAR, 0, 0, S_DONE, 0, 0, 0, 5);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
    cur_scen = 6;
    drive(1, C_STEP, 8'd4, 0, S_STEP, 1, 0, 0, 0);
    drive(1, C_RUN, 0, 0, S_STEP, 1, 0, 1, 1);
    drive(1, C_HALT, 0, 0, S_IDLE, 0, 1, 0, 2);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 2);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_collision_and_async_reset();
    cur_scen = 7;
    drive(1, C_RUN, 0, 0, S_RUN, 1, 0, 0, 0);
    drive(0, C_CLEAR, 0, 0, S_RUN, 1, 0, 0, 1);
    drive(1, C_HALT, 0, 1, S_DONE, 0, 1, 0, 2);
    drive(0, C_CLEAR, 0, 0, S_DONE, 0, 0, 0, 2);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
    cur_scen = 8;
    drive(1, C_RUN, 0, 0, S_RUN, 1, 0, 0, 0);
    drive(0, C_CLEAR, 0, 0, S_RUN, 1, 0, 0, 1);
    drive(0, C_CLEAR, 0, 0, S_RUN, 1, 0, 0, 2);
    settle();
    #1 i_reset = 1'b0;
    #1;
    tests++;
    if (o_state !== S_IDLE || o_pipeline_enable !== 1'b0 || o_done !== 1'b0 ||
        o_cmd_error !== 1'b0 || o_cycle_count !== 4'd0) begin
      fails++;
      $display("FAIL async_reset got st=%0d en=%0b done=%0b err=%0b cnt=%0d need all zero",
               o_state, o_pipeline_enable, o_done, o_cmd_error, o_cycle_count);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clock);
      #1;
      tests++;
      if (o_done !== 1'b0 || o_state !== S_IDLE) begin
        fails++;
        $display("FAIL reset_no_done got done=%0b st=%0d need done=0 st=0", o_done, o_state);
      end
    end
    @(negedge i_clock);
    i_reset = 1'b1;
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
    drive(1, C_STEP, 8'd1, 0, S_STEP, 1, 0, 0, 0);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 1, 0, 1);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    cur_scen = 9;
    drive(1, C_RUN, 0, 0, S_RUN, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) drive(0, C_CLEAR, 0, 0, S_RUN, 1, 0, 0, (k < 15) ? k : 15);
    drive(1, C_HALT, 0, 0, S_IDLE, 0, 1, 0, 15);
    drive(0, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 15);
    drive(1, C_CLEAR, 0, 0, S_IDLE, 0, 0, 0, 0);
    settle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending need 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_step3();
    test_step_zero();
    test_run_halt_detected();
    test_run_errors();
    test_step_halt_expiry();
    test_collision_and_async_reset();
    test_saturation();
    settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
